hs_ram_bridge: RTL and testbench
================================

# hs_ram_bridge

Game-side responder for the high-score save/restore engine. It arbitrates the shared work-RAM port between the game CPU and the high-score initiator. Each access follows one sequence: halt the CPU at a safe boundary, hand the RAM port to the initiator, return read data with fixed latency, then give the port back. The block sits inside the game core, between the CPU bus decode and the work-RAM instance, and is clocked by the system clock.

## Interface
Parameters:
- AW, 11, RAM address width
- DW, 8, RAM data width
- RD_LAT, 1, RAM read latency in cycles (legal 1..3)
- GUARD, 2, settle cycles between CPU halt acknowledge and grant (legal 0..15)

Ports:
- clk_sys  in  1  system clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- hs_access  in  1  initiator requests ownership of RAM
- hs_address  in  AW  initiator RAM address
- hs_data_in  in  DW  initiator write data
- hs_write  in  1  initiator write strobe
- hs_data_out  out  DW  registered read data to initiator
- hs_ready  out  1  initiator owns RAM
- hs_abort  out  1  sticky; CPU left halt while the initiator owned RAM
- cpu_pause_req  out  1  request CPU halt
- cpu_halted  in  1  CPU stopped at a bus-safe boundary
- cpu_addr  in  AW;  cpu_dout  in  DW;  cpu_we  in  1  CPU RAM bus
- cpu_din  out  DW  read data to CPU
- ram_addr  out  AW;  ram_din  out  DW;  ram_we  out  1;  ram_dout  in  DW  RAM port

## Operation
- FSM states: IDLE, HALT_WAIT, SETTLE, OWN, DRAIN. All outputs decode from the registered state (Moore).
- IDLE
  - RAM port = CPU bus.
  - hs_access=1 -> HALT_WAIT.
- HALT_WAIT
  - cpu_pause_req=1; RAM port still = CPU bus.
  - hs_access=0 -> IDLE, cancelling the pause.
  - Otherwise cpu_halted=1 -> SETTLE with cnt=GUARD-1, or -> OWN directly if GUARD=0.
- SETTLE
  - cpu_pause_req=1; ram_we forced 0.
  - cnt decrements each cycle; cnt=0 -> OWN.
  - hs_access=0 -> DRAIN.
- OWN
  - hs_ready=1; RAM port = initiator; ram_we = hs_write.
  - hs_access=0 -> DRAIN.
  - cpu_halted=0 -> DRAIN, hs_abort<=1, and ram_we is suppressed in that same cycle.
- DRAIN
  - ram_we=0; cpu_pause_req=1.
  - Lasts exactly RD_LAT cycles, then -> IDLE.
- hs_data_out: ram_dout passed through an RD_LAT-deep pipeline, captured only while the sampled address was issued in OWN. Outside OWN it holds its value.
- cpu_din: equals ram_dout when the port is CPU-owned. During SETTLE/OWN/DRAIN it holds the last CPU-owned value.
- Blocked strobes:
  - cpu_we is never forwarded outside IDLE/HALT_WAIT.
  - hs_write is never forwarded outside OWN.
- hs_abort clears only on reset.

## Timing
- Reset values: state IDLE, cpu_pause_req 0, hs_ready 0, hs_data_out 0, hs_abort 0, cpu_din 0, pipeline cleared.
- Reset asserted mid-operation: next cycle is IDLE and the pause is released immediately; no RAM write is issued in the reset cycle.
- hs_access rises at cycle n -> cpu_pause_req=1 at n+1.
- cpu_halted first sampled high at cycle m (in HALT_WAIT) -> hs_ready=1 from m+1+GUARD.
- Initiator read issued at cycle k in OWN -> hs_data_out valid at k+RD_LAT+1.
- Initiator write at cycle k in OWN -> ram_we=1 in cycle k (combinational mux from registered state).
- hs_access falls at cycle d in OWN:
  - hs_ready=0 at d+1.
  - cpu_pause_req=0 at d+1+RD_LAT.
  - CPU owns the RAM port from d+1+RD_LAT.
- Simultaneous hs_access=0 and cpu_halted=0 in OWN: treated as abort (hs_abort set).
- hs_access re-asserted during DRAIN: ignored until IDLE; it re-enters HALT_WAIT one cycle later.

## Structure
- Shared package hs_bridge_pkg:
  - state enum hs_state_t
  - legal-range constants RD_LAT_MAX=3, GUARD_MAX=15
  - elaboration-time parameter range checks
- One sub-module, hs_rd_pipe: an RD_LAT-deep data+valid shift register that produces hs_data_out.
- Muxing and the FSM live in the top module.

## Test plan
- Basic grant, AW=11, GUARD=2, RD_LAT=1:
  - Stimulus: hs_access at cycle 10; cpu_halted rises at 14.
  - Required: cpu_pause_req=1 at 11; hs_ready=1 at 17; no ram_we from the CPU side during 15..16.
- Write/read-back:
  - Stimulus: in OWN, write 0x5A to 0x123; then read 0x123.
  - Required: ram_we=1 for exactly one cycle; hs_data_out=0x5A two cycles after the read address.
- Cancel before halt:
  - Stimulus: hs_access drops in HALT_WAIT.
  - Required: IDLE next cycle; cpu_pause_req=0; hs_ready never asserted.
- Abort:
  - Stimulus: cpu_halted=0 while in OWN with hs_write=1 in the same cycle.
  - Required: ram_we=0; hs_abort=1 sticky; IDLE after RD_LAT cycles.
- Blocked CPU write:
  - Stimulus: cpu_we=1 with cpu_addr=0x010 during OWN.
  - Required: RAM contents at 0x010 unchanged; cpu_din holds its pre-grant value.
- Reset mid-OWN:
  - Stimulus: reset_n=0 for one cycle in OWN.
  - Required: next cycle hs_ready=0, cpu_pause_req=0, hs_data_out=0, hs_abort=0.

Source files
------------

// File: rtl/hs_bridge_pkg.sv
// Purpose: shared types, legal parameter ranges and a range-check helper for the high-score RAM bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hs_bridge_pkg;

    localparam int RD_LAT_MAX = 3;
    localparam int GUARD_MAX  = 15;
    localparam int CNT_W      = 4;   // wide enough for GUARD_MAX and RD_LAT_MAX

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_WAIT,
        ST_SETTLE,
        ST_OWN,
        ST_DRAIN
    } hs_state_t;

    // Evaluated at elaboration against the bridge parameters.
    function automatic bit params_ok(input int rd_lat, input int guard);
        return (rd_lat >= 1) && (rd_lat <= RD_LAT_MAX) &&
               (guard >= 0) && (guard <= GUARD_MAX);
    endfunction

endpackage

// File: rtl/hs_ram_bridge_if.sv
// Purpose: bundles the initiator handshake, CPU bus and work-RAM port seen by hs_ram_bridge.
// Latency: n/a (wiring only).
// Backpressure: n/a; hs_ready/cpu_pause_req carry the ownership handshake.
// Modports: slave = bridge view, master = surrounding core (initiator, CPU decode, RAM).
interface hs_ram_bridge_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          hs_access;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write;
    logic [DW-1:0] hs_data_out;
    logic          hs_ready;
    logic          hs_abort;
    logic          cpu_pause_req;
    logic          cpu_halted;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic          cpu_we;
    logic [DW-1:0] cpu_din;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  hs_access, hs_address, hs_data_in, hs_write,
        input  cpu_halted, cpu_addr, cpu_dout, cpu_we,
        input  ram_dout,
        output hs_data_out, hs_ready, hs_abort,
        output cpu_pause_req, cpu_din,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output hs_access, hs_address, hs_data_in, hs_write,
        output cpu_halted, cpu_addr, cpu_dout, cpu_we,
        output ram_dout,
        input  hs_data_out, hs_ready, hs_abort,
        input  cpu_pause_req, cpu_din,
        input  ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/hs_rd_pipe.sv
// Purpose: tracks which RAM reads were issued by the initiator and registers their data for it.
// Latency: address issued at k -> o_data updated at k+RD_LAT+1.
// Backpressure: none; output holds its value when no initiator read is completing.
// Ports: clk_sys/reset_n, i_issue (read issued in OWN), i_ram_dout (RAM read data), o_data.
module hs_rd_pipe #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          i_issue,
    input  logic [DW-1:0] i_ram_dout,
    output logic [DW-1:0] o_data
);

    // r_vld_sr[i] marks that the address issued i+1 cycles ago belonged to the initiator;
    // the top bit lines up with the RAM returning that address's data.
    logic [RD_LAT-1:0] r_vld_sr;
    logic [DW-1:0]     r_data;

    generate
        if (RD_LAT == 1) begin : g_sr1
            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= i_issue;
                end
            end
        end else begin : g_srn
            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= {r_vld_sr[RD_LAT-2:0], i_issue};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (r_vld_sr[RD_LAT-1]) begin
            r_data <= i_ram_dout;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/hs_ram_bridge.sv
// Purpose: hands the shared work-RAM port from the game CPU to the high-score initiator and back.
// Latency: pause 1 cycle after hs_access; grant GUARD+1 after halt ack; read data RD_LAT+1 after address.
// Backpressure: initiator waits on hs_ready; CPU is stalled through cpu_pause_req until the port is returned.
// Ports: clk_sys/reset_n plus bus (slave modport) carrying hs_* initiator, cpu_* CPU bus and ram_* RAM port.
module hs_ram_bridge
    import hs_bridge_pkg::*;
#(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int GUARD  = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    hs_ram_bridge_if.slave bus
);

    generate
        if (!params_ok(RD_LAT, GUARD)) begin : g_bad_param
            $error("hs_ram_bridge: RD_LAT must be 1..%0d and GUARD 0..%0d", RD_LAT_MAX, GUARD_MAX);
        end
    endgenerate

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RD_LAT - 1);

    hs_state_t        r_state;
    hs_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_abort;
    logic             w_abort_set;
    logic [DW-1:0]    r_cpu_hold;
    logic             w_cpu_own;
    logic             w_own;

    // ---------------- state register ----------------
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_abort_set) begin
                r_abort <= 1'b1;
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.hs_access) begin
                    w_state_nxt = ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                if (!bus.hs_access) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.cpu_halted) begin
                    if (GUARD == 0) begin
                        w_state_nxt = ST_OWN;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = GUARD_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (!bus.hs_access) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = DRAIN_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_OWN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_OWN: begin
                // Losing the halt wins over a normal release so the abort is never missed.
                if (!bus.cpu_halted) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = DRAIN_LOAD;
                    w_abort_set = 1'b1;
                end else if (!bus.hs_access) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // hs_access is deliberately ignored here; a new request is taken from IDLE.
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- port muxing (Moore on r_state) ----------------
    assign w_cpu_own = (r_state == ST_IDLE) || (r_state == ST_HALT_WAIT);
    assign w_own     = (r_state == ST_OWN);

    assign bus.ram_addr = w_cpu_own ? bus.cpu_addr : bus.hs_address;
    assign bus.ram_din  = w_cpu_own ? bus.cpu_dout : bus.hs_data_in;
    // Writes are gated by reset_n so a reset landing mid-OWN cannot corrupt RAM,
    // and by cpu_halted so the cycle the CPU escapes its halt never writes.
    assign bus.ram_we   = reset_n &&
                          (w_cpu_own ? bus.cpu_we
                                     : (w_own && bus.hs_write && bus.cpu_halted));

    assign bus.cpu_pause_req = (r_state != ST_IDLE);
    assign bus.hs_ready      = w_own;
    assign bus.hs_abort      = r_abort;

    // CPU sees live RAM data while it owns the port, otherwise the last value it could read.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_cpu_hold <= '0;
        end else if (w_cpu_own) begin
            r_cpu_hold <= bus.ram_dout;
        end
    end

    assign bus.cpu_din = w_cpu_own ? bus.ram_dout : r_cpu_hold;

    hs_rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_issue    (w_own),
        .i_ram_dout (bus.ram_dout),
        .o_data     (bus.hs_data_out)
    );

endmodule

// File: tb/tb_hs_ram_bridge.sv
// Purpose: directed self-checking bench for hs_ram_bridge with a behavioural 1-cycle work RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_hs_ram_bridge;

    localparam int AW = 11;
    localparam int DW = 8;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset_n;
    int   cyc;
    int   n_cmp = 0;
    int   n_err = 0;
    int   we_cnt;
    exp_t sb_q[$];

    logic [DW-1:0] mem [0:(1<<AW)-1];

    hs_ram_bridge_if #(.AW(AW), .DW(DW)) bus ();

    hs_ram_bridge #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (1),
        .GUARD  (2)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM, one cycle read latency.
    always @(posedge clk_sys) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
            we_cnt <= we_cnt + 1;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one cycle; registered outputs are sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk_sys);
        #1;
        cyc++;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("rd_data", 32'(bus.hs_data_out), 32'(e.data));
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[11'h010] = 8'h3C;
        bus.ram_dout   = '0;
        we_cnt         = 0;
        cyc            = 0;
        reset_n        = 1'b0;
        bus.hs_access  = 1'b0;
        bus.hs_address = '0;
        bus.hs_data_in = '0;
        bus.hs_write   = 1'b0;
        bus.cpu_halted = 1'b0;
        bus.cpu_addr   = 11'h010;
        bus.cpu_dout   = 8'hFF;
        bus.cpu_we     = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_ready", 32'(bus.hs_ready), 0);
        chk("rst_pause", 32'(bus.cpu_pause_req), 0);
        chk("rst_hs_dout", 32'(bus.hs_data_out), 0);
        chk("rst_abort", 32'(bus.hs_abort), 0);
        reset_n = 1'b1;
        cyc = 0;

        // ---- basic grant ----
        run_to(10);
        bus.hs_access  = 1'b1;
        bus.hs_address = 11'h123;
        tick();                                           // 11
        chk("grant_pause_11", 32'(bus.cpu_pause_req), 1);
        chk("grant_ready_11", 32'(bus.hs_ready), 0);
        chk("halt_wait_cpu_port", 32'(bus.ram_addr), 32'h010);
        run_to(14);
        bus.cpu_halted = 1'b1;
        tick();                                           // 15 SETTLE
        we_cnt = 0;
        bus.cpu_we = 1'b1;
        settle();
        chk("settle_we_15", 32'(bus.ram_we), 0);
        chk("settle_ready_15", 32'(bus.hs_ready), 0);
        tick();                                           // 16
        chk("settle_we_16", 32'(bus.ram_we), 0);
        chk("settle_ready_16", 32'(bus.hs_ready), 0);

        // ---- write / read-back, blocked CPU write ----
        tick();                                           // 17 OWN
        chk("grant_ready_17", 32'(bus.hs_ready), 1);
        chk("grant_pause_17", 32'(bus.cpu_pause_req), 1);
        bus.hs_write   = 1'b1;
        bus.hs_data_in = 8'h5A;
        settle();
        chk("own_we", 32'(bus.ram_we), 1);
        chk("own_addr", 32'(bus.ram_addr), 32'h123);
        chk("own_din", 32'(bus.ram_din), 32'h5A);
        chk("cpu_din_hold", 32'(bus.cpu_din), 32'h3C);
        tick();                                           // 18 read 0x123
        bus.hs_write = 1'b0;
        sb_q.push_back('{due: cyc + 2, data: 8'h5A});
        settle();
        chk("own_rd_we", 32'(bus.ram_we), 0);
        tick();                                           // 19 read 0x010
        bus.hs_address = 11'h010;
        sb_q.push_back('{due: cyc + 2, data: 8'h3C});
        tick();                                           // 20 release
        bus.hs_access = 1'b0;
        bus.cpu_we    = 1'b0;
        tick();                                           // 21 DRAIN
        chk("drain_ready", 32'(bus.hs_ready), 0);
        chk("drain_pause", 32'(bus.cpu_pause_req), 1);
        bus.cpu_halted = 1'b0;
        tick();                                           // 22 IDLE
        chk("release_pause", 32'(bus.cpu_pause_req), 0);
        chk("release_port", 32'(bus.ram_addr), 32'h010);
        chk("hs_dout_hold", 32'(bus.hs_data_out), 32'h3C);
        chk("we_once", 32'(we_cnt), 1);
        tick();                                           // 23
        chk("cpu_din_live", 32'(bus.cpu_din), 32'h3C);

        // ---- cancel before halt ----
        run_to(30);
        bus.hs_access = 1'b1;
        tick();                                           // 31 HALT_WAIT
        chk("cancel_pause_on", 32'(bus.cpu_pause_req), 1);
        bus.hs_access = 1'b0;
        tick();                                           // 32 IDLE
        chk("cancel_pause_off", 32'(bus.cpu_pause_req), 0);
        chk("cancel_ready_32", 32'(bus.hs_ready), 0);
        tick();
        chk("cancel_ready_33", 32'(bus.hs_ready), 0);

        // ---- abort, plus re-request during DRAIN ----
        run_to(40);
        bus.hs_access = 1'b1;
        tick();                                           // 41 HALT_WAIT
        bus.cpu_halted = 1'b1;
        run_to(44);                                       // 44 OWN
        chk("abort_ready", 32'(bus.hs_ready), 1);
        chk("abort_pre", 32'(bus.hs_abort), 0);
        bus.hs_address = 11'h200;
        bus.hs_data_in = 8'h77;
        bus.hs_write   = 1'b1;
        bus.cpu_halted = 1'b0;
        settle();
        chk("abort_we", 32'(bus.ram_we), 0);
        tick();                                           // 45 DRAIN
        bus.hs_write = 1'b0;
        chk("abort_set", 32'(bus.hs_abort), 1);
        chk("abort_drain_pause", 32'(bus.cpu_pause_req), 1);
        chk("abort_drain_ready", 32'(bus.hs_ready), 0);
        tick();                                           // 46 IDLE
        chk("abort_idle_pause", 32'(bus.cpu_pause_req), 0);
        tick();                                           // 47 HALT_WAIT again
        chk("rereq_pause", 32'(bus.cpu_pause_req), 1);
        bus.hs_access = 1'b0;
        tick();                                           // 48
        chk("abort_sticky", 32'(bus.hs_abort), 1);

        // ---- reset mid-OWN ----
        run_to(50);
        bus.hs_access  = 1'b1;
        bus.hs_address = 11'h123;
        tick();                                           // 51
        bus.cpu_halted = 1'b1;
        run_to(54);                                       // 54 OWN, read 0x123
        chk("rst_own_ready", 32'(bus.hs_ready), 1);
        sb_q.push_back('{due: cyc + 2, data: 8'h5A});
        run_to(56);
        reset_n        = 1'b0;
        bus.hs_address = 11'h300;
        bus.hs_data_in = 8'h99;
        bus.hs_write   = 1'b1;
        settle();
        chk("rst_cycle_we", 32'(bus.ram_we), 0);
        tick();                                           // 57
        reset_n        = 1'b1;
        bus.hs_access  = 1'b0;
        bus.hs_write   = 1'b0;
        bus.cpu_halted = 1'b0;
        chk("midrst_ready", 32'(bus.hs_ready), 0);
        chk("midrst_pause", 32'(bus.cpu_pause_req), 0);
        chk("midrst_hs_dout", 32'(bus.hs_data_out), 0);
        chk("midrst_abort", 32'(bus.hs_abort), 0);
        tick();
        chk("midrst_idle", 32'(bus.cpu_pause_req), 0);

        // ---- final RAM contents ----
        chk("mem_123", 32'(mem[11'h123]), 32'h5A);
        chk("mem_010", 32'(mem[11'h010]), 32'h3C);
        chk("mem_200", 32'(mem[11'h200]), 0);
        chk("mem_300", 32'(mem[11'h300]), 0);
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
